// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock through a
// single full-subtractor cell and a borrow flip-flop. The result is packed
// as {borrow_out, difference}, matching the ripple adder's SUM layout.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   diff
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_diff;

  logic             w_load;
  logic             w_last;
  logic             w_d;
  logic             w_nbr;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign w_d    = r_a[0] ^ r_b[0] ^ r_br;
  assign w_nbr  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

  // A new request is accepted whenever no shift is in progress (IDLE or DONE).
  assign w_load = start && (r_state != SHIFT);
  assign w_last = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand shifters, borrow FF, bit counter and result capture.
  // The result register keeps only the first WIDTH-1 bits; the final bit and
  // borrow are taken straight from the cell on the last shift so diff is
  // already valid during the DONE cycle and untouched by a back-to-back load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_nbr;
      r_res <= (WIDTH-1)'({w_d, r_res} >> 1);
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff <= {w_nbr, w_d, r_res};
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign diff = r_diff;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   diff;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called just after the start edge; returns ticks until done is seen and
  // how many of the observed cycles had busy high.
  task automatic wait_done(input string tag, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    if (!done) check({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  // One full operation with timing and result checks.
  task automatic do_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ibin, input logic [8:0] exp);
    int lat;
    int bc;
    a = ia; b = ib; bin = ibin; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    wait_done(tag, lat, bc);
    check({tag, "_latency"}, 32'(lat + 1), 32'd9);
    check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'(exp));
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_diff_hold"}, 32'(diff), 32'(exp));
  endtask

  initial begin
    int lat;
    int bc;
    int ndone;
    logic [8:0] cap;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_diff", 32'(diff), 32'd0);
    end

    do_op("sub_200_100", 8'd200, 8'd100, 1'b0, 9'd100);
    do_op("sub_5_10",    8'd5,   8'd10,  1'b0, 9'h1FB);
    do_op("sub_0_0_b1",  8'd0,   8'd0,   1'b1, 9'h1FF);
    do_op("sub_ff_ff_b1",8'd255, 8'd255, 1'b1, 9'h1FF);
    do_op("sub_ff_0",    8'd255, 8'd0,   1'b0, 9'h0FF);

    // Start during busy must be ignored.
    a = 8'd50; b = 8'd20; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'd1; b = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; cap = '0; lat = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        ndone++;
        cap = diff;
        if (ndone == 1) lat = i + 3;
      end
      tick();
    end
    check("ignore_done_count", 32'(ndone), 32'd1);
    check("ignore_latency", 32'(lat + 1), 32'd9);
    check("ignore_diff", 32'(cap), 32'd30);

    // Back-to-back: new start in the DONE cycle.
    a = 8'd9; b = 8'd6; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("b2b_first", lat, bc);
    check("b2b_first_latency", 32'(lat + 1), 32'd9);
    check("b2b_first_diff", 32'(diff), 32'd3);
    a = 8'd3; b = 8'd4; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_accepted_busy", 32'(busy), 32'd1);
    check("b2b_diff_undisturbed", 32'(diff), 32'd3);
    wait_done("b2b_second", lat, bc);
    check("b2b_second_latency", 32'(lat + 1), 32'd9);
    check("b2b_second_diff", 32'(diff), 32'h1FF);
    tick();

    // Reset in the middle of an operation.
    a = 8'd100; b = 8'd1; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      tick();
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    do_op("sub_7_2_b1", 8'd7, 8'd2, 1'b1, 9'd4);

    // rst and start together: start not accepted.
    a = 8'd10; b = 8'd1; bin = 1'b0; start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_diff", 32'(diff), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
